ssd13xx_spi4_decoder: RTL and testbench



---
 rtl/ssd13xx_pkg.sv | 35 +++
 rtl/ssd13xx_wr_fifo.sv | 41 ++++
 rtl/ssd13xx_spi4_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_ssd13xx_spi4_decoder.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd13xx_pkg.sv
// Shared command codes, modes and the frame-buffer write entry for the SSD13xx SPI decoder.
package ssd13xx_pkg;

  localparam logic [7:0] CMD_ENTIRE_ON  = 8'hA4;
  localparam logic [7:0] CMD_INVERSE    = 8'hA6;
  localparam logic [7:0] CMD_ONOFF      = 8'hAE;
  localparam logic [7:0] CMD_SEG_REMAP  = 8'hA0;
  localparam logic [7:0] CMD_COM_DIR    = 8'hC0;
  localparam logic [7:0] CMD_ADR_MODE   = 8'h20;
  localparam logic [7:0] CMD_COL_ADDR   = 8'h21;
  localparam logic [7:0] CMD_PAGE_ADDR  = 8'h22;
  localparam logic [7:0] CMD_CONTRAST   = 8'h81;
  localparam logic [7:0] CMD_PAGE_START = 8'hB0;

  typedef enum logic [1:0] {
    ADR_HORIZ   = 2'd0,
    ADR_VERT    = 2'd1,
    ADR_PAGE    = 2'd2,
    ADR_INVALID = 2'd3
  } adr_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARG1 = 2'd1,
    ST_ARG2 = 2'd2
  } cmd_state_e;

  // Sized for the largest supported panel; the top trims to its own widths.
  typedef struct packed {
    logic [7:0] col;
    logic [7:0] page;
    logic [7:0] data;
  } wr_entry_t;

endpackage

// File: rtl/ssd13xx_wr_fifo.sv
// Generic synchronous FIFO; a pop in the same cycle frees room for a push while full.
module ssd13xx_wr_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     data_o,
  output logic full_o,
  output logic empty_o
);
  localparam int AW = $clog2(DEPTH);

  T           r_mem [DEPTH];
  logic [AW:0] r_wr, r_rd;
  logic       w_pop, w_push;

  assign empty_o = (r_wr == r_rd);
  assign full_o  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign data_o  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/ssd13xx_spi4_decoder.sv
// SSD1306-style 4-wire SPI front end: oversampled shifter, command decoder,
// address pointers and a buffered column/page/data write stream.
module ssd13xx_spi4_decoder
  import ssd13xx_pkg::*;
#(
  parameter  int DISP_WIDTH  = 128,
  parameter  int DISP_HEIGHT = 64,
  parameter  int FIFO_DEPTH  = 4,
  localparam int PAGES = DISP_HEIGHT / 8,
  localparam int CW    = $clog2(DISP_WIDTH),
  localparam int PW    = (PAGES > 1) ? $clog2(PAGES) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          cs_in,
  input  logic          sck_i,
  input  logic          sdi_i,
  input  logic          dc_i,
  output logic          wr_valid_o,
  input  logic          wr_ready_i,
  output logic [CW-1:0] wr_col_o,
  output logic [PW-1:0] wr_page_o,
  output logic [7:0]    wr_data_o,
  output logic          disp_on_o,
  output logic          inverse_o,
  output logic          entire_on_o,
  output logic          flip_x_o,
  output logic          flip_y_o,
  output logic [1:0]    adr_mode_o,
  output logic [7:0]    contrast_o,
  output logic          overflow_o
);

  // Synchronisers carry no reset: they must track the live pins through rst_i.
  logic [1:0] r_cs_sync, r_sck_sync, r_sdi_sync, r_dc_sync;
  logic       r_sck_d;
  logic       w_cs, w_sdi, w_dc, w_sck_rise;

  always_ff @(posedge clk_i) begin
    r_cs_sync  <= {r_cs_sync[0], cs_in};
    r_sck_sync <= {r_sck_sync[0], sck_i};
    r_sdi_sync <= {r_sdi_sync[0], sdi_i};
    r_dc_sync  <= {r_dc_sync[0], dc_i};
    r_sck_d    <= r_sck_sync[1];
  end

  assign w_cs       = r_cs_sync[1];
  assign w_sdi      = r_sdi_sync[1];
  assign w_dc       = r_dc_sync[1];
  assign w_sck_rise = r_sck_sync[1] && !r_sck_d;

  // r_armed blocks a frame already in flight at reset until cs is seen high.
  logic [2:0] r_bitcnt;
  logic [7:0] r_shift, r_byte;
  logic       r_byte_v, r_byte_dc, r_armed;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bitcnt  <= '0;
      r_armed   <= 1'b0;
      r_byte_v  <= 1'b0;
      r_shift   <= '0;
      r_byte    <= '0;
      r_byte_dc <= 1'b0;
    end else begin
      r_byte_v <= 1'b0;
      if (w_cs) begin
        r_bitcnt <= '0;
        r_armed  <= 1'b1;
      end else if (r_armed && w_sck_rise) begin
        r_shift  <= {r_shift[6:0], w_sdi};
        r_bitcnt <= r_bitcnt + 1'b1;
        if (r_bitcnt == 3'd7) begin
          r_byte_v  <= 1'b1;
          r_byte    <= {r_shift[6:0], w_sdi};
          r_byte_dc <= w_dc;
        end
      end
    end
  end

  cmd_state_e r_state;
  adr_mode_e  r_mode;
  logic [7:0] r_cmd, r_contrast;
  logic       r_disp_on, r_inverse, r_entire_on, r_flip_x, r_flip_y, r_overflow;
  logic [CW-1:0] r_col, r_col_start, r_col_end, r_pcol_start;
  logic [PW-1:0] r_page, r_page_start, r_page_end;

  logic       w_push, w_pop, w_full, w_empty, w_col_wrap, w_page_wrap;
  logic [7:0] w_pcol8, w_pcol_new;
  int         w_bnum;
  wr_entry_t  w_wr_in, w_wr_out;

  assign w_col_wrap  = (r_col == r_col_end) || (r_col == CW'(DISP_WIDTH - 1));
  assign w_page_wrap = (r_page == r_page_end) || (r_page == PW'(PAGES - 1));
  assign w_push      = r_byte_v && r_byte_dc && (r_mode != ADR_INVALID);
  assign w_pop       = wr_valid_o && wr_ready_i;
  assign w_wr_in     = '{col: 8'(r_col), page: 8'(r_page), data: r_byte};
  assign w_pcol8     = 8'(r_pcol_start);
  assign w_pcol_new  = r_byte[4] ? {r_byte[3:0], w_pcol8[3:0]} : {w_pcol8[7:4], r_byte[3:0]};
  assign w_bnum      = int'(r_byte[3:0]) % PAGES;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_IDLE;
      r_mode       <= ADR_PAGE;
      r_cmd        <= '0;
      r_contrast   <= 8'h7F;
      r_disp_on    <= 1'b0;
      r_inverse    <= 1'b0;
      r_entire_on  <= 1'b0;
      r_flip_x     <= 1'b0;
      r_flip_y     <= 1'b0;
      r_overflow   <= 1'b0;
      r_col        <= '0;
      r_col_start  <= '0;
      r_col_end    <= CW'(DISP_WIDTH - 1);
      r_pcol_start <= '0;
      r_page       <= '0;
      r_page_start <= '0;
      r_page_end   <= PW'(PAGES - 1);
    end else begin
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (r_byte_v && r_byte_dc) begin
        // Data aborts any half-received multi-byte command.
        r_state <= ST_IDLE;
        unique case (r_mode)
          ADR_HORIZ:
            if (w_col_wrap) begin
              r_col  <= r_col_start;
              r_page <= w_page_wrap ? r_page_start : r_page + 1'b1;
            end else r_col <= r_col + 1'b1;
          ADR_VERT:
            if (w_page_wrap) begin
              r_page <= r_page_start;
              r_col  <= w_col_wrap ? r_col_start : r_col + 1'b1;
            end else r_page <= r_page + 1'b1;
          ADR_PAGE:    r_col <= w_col_wrap ? r_pcol_start : r_col + 1'b1;
          ADR_INVALID: ;
        endcase
      end else if (r_byte_v) begin
        unique case (r_state)
          ST_IDLE: begin
            r_cmd <= r_byte;
            if (r_byte == CMD_ADR_MODE || r_byte == CMD_CONTRAST ||
                r_byte == CMD_COL_ADDR || r_byte == CMD_PAGE_ADDR)
              r_state <= ST_ARG1;
            else if (r_byte[7:1] == CMD_ENTIRE_ON[7:1]) r_entire_on <= r_byte[0];
            else if (r_byte[7:1] == CMD_INVERSE[7:1])   r_inverse   <= r_byte[0];
            else if (r_byte[7:1] == CMD_ONOFF[7:1])     r_disp_on   <= r_byte[0];
            else if (r_byte[7:1] == CMD_SEG_REMAP[7:1]) r_flip_x    <= r_byte[0];
            else if (r_byte == CMD_COM_DIR)             r_flip_y    <= 1'b0;
            else if (r_byte == (CMD_COM_DIR | 8'h08))   r_flip_y    <= 1'b1;
            else if (r_byte[7:4] == CMD_PAGE_START[7:4]) r_page     <= PW'(w_bnum);
            else if (r_byte[7:5] == 3'b000) begin
              r_pcol_start <= w_pcol_new[CW-1:0];
              r_col        <= w_pcol_new[CW-1:0];
            end
          end
          ST_ARG1: begin
            r_state <= ST_IDLE;
            case (r_cmd)
              CMD_ADR_MODE: r_mode     <= adr_mode_e'(r_byte[1:0]);
              CMD_CONTRAST: r_contrast <= r_byte;
              CMD_COL_ADDR: begin
                r_col_start <= r_byte[CW-1:0];
                r_col       <= r_byte[CW-1:0];
                r_state     <= ST_ARG2;
              end
              CMD_PAGE_ADDR: begin
                r_page_start <= r_byte[PW-1:0];
                r_page       <= r_byte[PW-1:0];
                r_state      <= ST_ARG2;
              end
              default: ;
            endcase
          end
          ST_ARG2: begin
            r_state <= ST_IDLE;
            if (r_cmd == CMD_COL_ADDR) r_col_end  <= r_byte[CW-1:0];
            else                       r_page_end <= r_byte[PW-1:0];
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  ssd13xx_wr_fifo #(.T(wr_entry_t), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_wr_in),
    .pop_i   (wr_ready_i),
    .data_o  (w_wr_out),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  logic w_unused;
  assign w_unused = ^{w_wr_out.col, w_wr_out.page};

  assign wr_valid_o  = !w_empty;
  assign wr_col_o    = w_wr_out.col[CW-1:0];
  assign wr_page_o   = w_wr_out.page[PW-1:0];
  assign wr_data_o   = w_wr_out.data;
  assign disp_on_o   = r_disp_on;
  assign inverse_o   = r_inverse;
  assign entire_on_o = r_entire_on;
  assign flip_x_o    = r_flip_x;
  assign flip_y_o    = r_flip_y;
  assign adr_mode_o  = r_mode;
  assign contrast_o  = r_contrast;
  assign overflow_o  = r_overflow;

endmodule

// File: tb/tb_ssd13xx_spi4_decoder.sv
// Randomised bench for ssd13xx_spi4_decoder: SPI driver, display-state model and write scoreboard.
module tb_ssd13xx_spi4_decoder;
  localparam int W = 128, P = 8, FD = 4;

  logic clk = 0, rst = 1, cs = 1, sck = 0, sdi = 0, dc = 0, wr_ready;
  logic wr_valid, disp_on, inverse, entire_on, flip_x, flip_y, overflow;
  logic [6:0] wr_col;
  logic [2:0] wr_page;
  logic [7:0] wr_data, contrast;
  logic [1:0] adr_mode;

  ssd13xx_spi4_decoder #(.DISP_WIDTH(W), .DISP_HEIGHT(P*8), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_i(rst), .cs_in(cs), .sck_i(sck), .sdi_i(sdi), .dc_i(dc),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_col_o(wr_col), .wr_page_o(wr_page),
    .wr_data_o(wr_data), .disp_on_o(disp_on), .inverse_o(inverse), .entire_on_o(entire_on),
    .flip_x_o(flip_x), .flip_y_o(flip_y), .adr_mode_o(adr_mode), .contrast_o(contrast),
    .overflow_o(overflow));

  always #5 clk = ~clk;

  typedef struct {int col; int page; int data;} exp_t;
  exp_t q[$];
  exp_t mon_e;
  int total = 0, bad = 0, ready_mode = 1;

  // Display state as the panel documentation describes it.
  int m_col, m_page, m_cs, m_ce, m_ps, m_pe, m_pcs, m_mode, m_con, m_st, m_cmd;
  bit m_on, m_inv, m_ent, m_fx, m_fy, m_auto;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_col = 0; m_page = 0; m_cs = 0; m_ce = W-1; m_ps = 0; m_pe = P-1; m_pcs = 0;
    m_mode = 2; m_con = 'h7F; m_st = 0; m_cmd = 0;
    {m_on, m_inv, m_ent, m_fx, m_fy} = '0;
  endtask

  task automatic model_byte(bit d, int b);
    bit cw, pw;
    if (d) begin
      m_st = 0;
      if (m_mode == 3) return;
      if (m_auto) q.push_back('{m_col, m_page, b});
      cw = (m_col == m_ce) || (m_col == W-1);
      pw = (m_page == m_pe) || (m_page == P-1);
      if (m_mode == 0) begin
        if (cw) begin m_col = m_cs; m_page = pw ? m_ps : m_page + 1; end else m_col++;
      end else if (m_mode == 1) begin
        if (pw) begin m_page = m_ps; m_col = cw ? m_cs : m_col + 1; end else m_page++;
      end else m_col = cw ? m_pcs : m_col + 1;
    end else if (m_st == 1) begin
      m_st = 0;
      case (m_cmd)
        'h20: m_mode = b % 4;
        'h81: m_con = b;
        'h21: begin m_cs = b % W; m_col = m_cs; m_st = 2; end
        'h22: begin m_ps = b % P; m_page = m_ps; m_st = 2; end
        default: ;
      endcase
    end else if (m_st == 2) begin
      m_st = 0;
      if (m_cmd == 'h21) m_ce = b % W; else m_pe = b % P;
    end else begin
      m_cmd = b;
      case (b)
        'h20, 'h81, 'h21, 'h22: m_st = 1;
        'hA4, 'hA5: m_ent = b[0];
        'hA6, 'hA7: m_inv = b[0];
        'hAE, 'hAF: m_on = b[0];
        'hA0, 'hA1: m_fx = b[0];
        'hC0: m_fy = 0;
        'hC8: m_fy = 1;
        default:
          if (b / 16 == 'hB) m_page = (b % 16) % P;
          else if (b < 16) begin m_pcs = ((m_pcs / 16) * 16 + b) % W; m_col = m_pcs; end
          else if (b < 32) begin m_pcs = ((b % 16) * 16 + m_pcs % 16) % W; m_col = m_pcs; end
      endcase
    end
  endtask

  task automatic shift_bits(int b, int n, bit d);
    for (int i = n-1; i >= 0; i--) begin
      sdi = b[i]; dc = d;
      repeat (2) @(negedge clk); sck = 1;
      repeat (2) @(negedge clk); sck = 0;
    end
  endtask

  task automatic send_byte(bit d, int b);
    model_byte(d, b);
    @(negedge clk); cs = 0;
    shift_bits(b, 8, d);
    repeat (2) @(negedge clk); cs = 1;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_status();
    chk("disp_on", disp_on, m_on);
    chk("inverse", inverse, m_inv);
    chk("entire_on", entire_on, m_ent);
    chk("flip_x", flip_x, m_fx);
    chk("flip_y", flip_y, m_fy);
    chk("adr_mode", adr_mode, m_mode);
    chk("contrast", contrast, m_con);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000 && q.size() != 0; i++) @(negedge clk);
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic push(int c, int p, int d);
    q.push_back('{c, p, d});
  endtask

  initial begin
    wr_ready = 0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0: wr_ready = 0;
        1: wr_ready = 1;
        default: wr_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst && wr_valid && wr_ready) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got (%0d,%0d,%02h) expected none", wr_col, wr_page, wr_data);
      end else begin
        mon_e = q.pop_front();
        if (wr_col != mon_e.col || wr_page != mon_e.page || wr_data != mon_e.data) begin
          bad++;
          $display("FAIL write: got (%0d,%0d,%02h) expected (%0d,%0d,%02h)",
                   wr_col, wr_page, wr_data, mon_e.col, mon_e.page, mon_e.data);
        end
      end
    end
  end

  initial begin
    int k, n;
    model_reset(); m_auto = 0;
    repeat (5) @(negedge clk); rst = 0;
    repeat (4) @(negedge clk);
    chk("rst_valid", wr_valid, 0);
    chk("rst_overflow", overflow, 0);
    check_status();

    send_byte(0, 'hAF); send_byte(0, 'hA7); send_byte(0, 'hA1); send_byte(0, 'hC8);
    chk("status_on", disp_on, 1); chk("status_inv", inverse, 1);
    chk("status_fx", flip_x, 1); chk("status_fy", flip_y, 1);
    chk("status_con", contrast, 'h7F); chk("status_mode", adr_mode, 2);

    // Horizontal inside a 2x2 window.
    send_byte(0, 'h20); send_byte(0, 'h00);
    send_byte(0, 'h21); send_byte(0, 'h7E); send_byte(0, 'h7F);
    send_byte(0, 'h22); send_byte(0, 'h06); send_byte(0, 'h07);
    push(126, 6, 1); push(127, 6, 2); push(126, 7, 3); push(127, 7, 4); push(126, 6, 5);
    for (int i = 1; i <= 5; i++) send_byte(1, i);
    wait_drain();

    // Vertical over columns 0..1.
    send_byte(0, 'h20); send_byte(0, 'h01);
    send_byte(0, 'h21); send_byte(0, 'h00); send_byte(0, 'h01);
    send_byte(0, 'h22); send_byte(0, 'h00); send_byte(0, 'h07);
    for (int i = 0; i < 8; i++) push(0, i, 'h40 + i);
    push(1, 0, 'h48);
    for (int i = 0; i < 9; i++) send_byte(1, 'h40 + i);
    wait_drain();
    chk("mode_vert", adr_mode, 1);

    // Page mode with nibble column start.
    send_byte(0, 'h20); send_byte(0, 'h02);
    send_byte(0, 'hB3); send_byte(0, 'h05); send_byte(0, 'h12);
    push('h25, 3, 'hD0); push('h26, 3, 'hD1);
    send_byte(1, 'hD0); send_byte(1, 'hD1);
    send_byte(0, 'h21); send_byte(0, 'h00); send_byte(0, 'h7F);
    send_byte(0, 'h05); send_byte(0, 'h12);
    for (int i = 0; i < 91; i++) push('h25 + i, 3, i);
    push('h25, 3, 'hEE);
    for (int i = 0; i < 91; i++) send_byte(1, i);
    send_byte(1, 'hEE);
    wait_drain();

    // Data aborts a pending 21; A6 afterwards must act as a command.
    send_byte(0, 'h21);
    push('h26, 3, 'h77);
    send_byte(1, 'h77);
    send_byte(0, 'hA6);
    wait_drain();
    chk("abort_idle_inverse", inverse, 0);

    // Random traffic against the model.
    m_auto = 1; ready_mode = 2;
    for (int it = 0; it < 45; it++) begin
      k = $urandom_range(0, 9);
      case (k)
        0: begin
          int sb[10] = '{'hA4, 'hA5, 'hA6, 'hA7, 'hAE, 'hAF, 'hA0, 'hA1, 'hC0, 'hC8};
          send_byte(0, sb[$urandom_range(0, 9)]);
        end
        1: begin send_byte(0, 'h20); send_byte(0, $urandom_range(0, 255)); end
        2: begin send_byte(0, 'h81); send_byte(0, $urandom_range(0, 255)); end
        3: begin send_byte(0, 'h21); send_byte(0, $urandom_range(0, 255)); send_byte(0, $urandom_range(0, 255)); end
        4: begin send_byte(0, 'h22); send_byte(0, $urandom_range(0, 255)); send_byte(0, $urandom_range(0, 255)); end
        5: send_byte(0, 'hB0 + $urandom_range(0, 15));
        6: send_byte(0, $urandom_range(0, 31));
        7: send_byte(0, $urandom_range(0, 255));
        default: begin
          n = $urandom_range(1, 6);
          for (int j = 0; j < n; j++) send_byte(1, $urandom_range(0, 255));
        end
      endcase
      check_status();
    end
    ready_mode = 1;
    wait_drain();

    // Overflow: FD entries kept, one dropped, pointer still advances.
    send_byte(0, 'h20); send_byte(0, 'h00);
    send_byte(0, 'h21); send_byte(0, 'h00); send_byte(0, 'h7F);
    send_byte(0, 'h22); send_byte(0, 'h00); send_byte(0, 'h07);
    wait_drain();
    m_auto = 0; ready_mode = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i <= FD; i++) begin
      if (i < FD) push(i, 0, 'h10 + i);
      send_byte(1, 'h10 + i);
    end
    chk("overflow_set", overflow, 1);
    ready_mode = 1;
    wait_drain();
    push(FD + 1, 0, 'h20);
    send_byte(1, 'h20);
    wait_drain();

    // Reset mid-byte with entries still buffered.
    ready_mode = 0;
    repeat (2) @(negedge clk);
    send_byte(1, 'h30); send_byte(1, 'h31);
    chk("prereset_valid", wr_valid, 1);
    cs = 0; shift_bits('hC3, 4, 1);
    rst = 1; repeat (2) @(negedge clk); rst = 0;
    q.delete(); model_reset();
    repeat (3) @(negedge clk);
    chk("rst2_valid", wr_valid, 0);
    chk("rst2_overflow", overflow, 0);
    check_status();
    // A full byte while cs never went high must be ignored.
    ready_mode = 1;
    shift_bits('hAA, 8, 1);
    repeat (2) @(negedge clk); cs = 1;
    repeat (10) @(negedge clk);
    chk("stale_frame_valid", wr_valid, 0);
    m_auto = 1;
    send_byte(1, 'h55);
    send_byte(0, 'hA5);
    wait_drain();
    check_status();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
